// File: rtl/jump_reg_ctrl_if.sv
// jump_reg_ctrl_if: decode-side bundle between the decode stage and the
// register-jump controller. The master drives the decoded instruction and
// operand; the slave (jump_reg_ctrl) returns stall, redirect, link, flush
// and alignment-error signals.
interface jump_reg_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             valid_in;
  logic [1:0]       alu_op;
  logic [5:0]       fn;
  logic             rs_ready;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] pc_plus4;
  logic             jr_control;
  logic             stall_out;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             link_valid;
  logic [WIDTH-1:0] link_data;
  logic             flush;
  logic             addr_err;

  modport master (
    output valid_in, alu_op, fn, rs_ready, rs_data, pc_plus4,
    input  jr_control, stall_out, redirect_valid, redirect_pc,
           link_valid, link_data, flush, addr_err
  );

  modport slave (
    input  valid_in, alu_op, fn, rs_ready, rs_data, pc_plus4,
    output jr_control, stall_out, redirect_valid, redirect_pc,
           link_valid, link_data, flush, addr_err
  );
endinterface

// File: rtl/jump_reg_ctrl.sv
// jump_reg_ctrl: sequenced JR/JALR handling beside the decode stage.
// Decodes the register jump, stalls decode until rs is available, captures
// the target, issues a one-cycle registered redirect and holds flush for
// FLUSH_STAGES cycles. Misaligned targets abort with a one-cycle addr_err.
// Optional feature macro JUMP_REG_JALR_EN enables JALR decode and the link
// value outputs; when undefined only JR decodes and link outputs are 0.
module jump_reg_ctrl #(
  parameter int WIDTH        = 32,
  parameter int FLUSH_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  jump_reg_ctrl_if.slave bus
);

  localparam int CW = $clog2(FLUSH_STAGES) + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RS  = 2'd1,
    REDIRECT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] target_reg;
  logic             addr_err_reg;
  logic             jr_hit;
  logic             jalr_hit;
  logic             hit;
  logic             capture;
  logic             misaligned;
  logic             stall;

  assign jr_hit = (bus.alu_op == 2'b10) && (bus.fn == 6'b001000);

`ifdef JUMP_REG_JALR_EN
  logic [WIDTH-1:0] link_reg;
  logic             jalr_reg;

  assign jalr_hit = (bus.alu_op == 2'b10) && (bus.fn == 6'b001001);

  // Capture the link value and JALR flag alongside the jump target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_reg <= '0;
      jalr_reg <= 1'b0;
    end else if (capture) begin
      link_reg <= bus.pc_plus4;
      jalr_reg <= jalr_hit;
    end
  end

  assign bus.link_valid = (state_reg == REDIRECT) && jalr_reg;
  assign bus.link_data  = link_reg;
`else
  logic unused_pc;

  assign jalr_hit       = 1'b0;
  assign unused_pc      = ^bus.pc_plus4;
  assign bus.link_valid = 1'b0;
  assign bus.link_data  = '0;
`endif

  assign hit        = jr_hit || jalr_hit;
  assign misaligned = (bus.rs_data[1:0] != 2'b00);

  // State and flush counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state, capture strobe and state-decoded outputs
  always_comb begin
    state_next         = state_reg;
    cnt_next           = cnt_reg;
    capture            = 1'b0;
    stall              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.flush          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.valid_in && hit) begin
          if (bus.rs_ready) begin
            capture    = 1'b1;
            state_next = misaligned ? IDLE : REDIRECT;
          end else begin
            stall      = 1'b1;
            state_next = WAIT_RS;
          end
        end
      end
      WAIT_RS: begin
        // Decode inputs are held by the stall, so hit is not re-evaluated
        stall = !bus.rs_ready;
        if (!bus.valid_in) begin
          state_next = IDLE;
        end else if (bus.rs_ready) begin
          capture    = 1'b1;
          state_next = misaligned ? IDLE : REDIRECT;
        end
      end
      REDIRECT: begin
        bus.redirect_valid = 1'b1;
        bus.flush          = 1'b1;
        if (FLUSH_STAGES == 1) begin
          state_next = IDLE;
        end else begin
          cnt_next   = CW'(FLUSH_STAGES - 1);
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        // Younger instructions are being squashed; decode is ignored here
        bus.flush = 1'b1;
        if (cnt_reg <= CW'(1)) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Target capture and one-cycle misaligned-target flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_reg   <= '0;
      addr_err_reg <= 1'b0;
    end else begin
      addr_err_reg <= capture && misaligned;
      if (capture) begin
        target_reg <= bus.rs_data;
      end
    end
  end

  // Combinational outputs are forced low while reset is asserted
  assign bus.jr_control  = rst_n && bus.valid_in && hit;
  assign bus.stall_out   = rst_n && stall;
  assign bus.redirect_pc = target_reg;
  assign bus.addr_err    = addr_err_reg;

endmodule

// File: tb/tb_jump_reg_ctrl.sv
// tb_jump_reg_ctrl: directed and randomized jump transactions checked
// cycle by cycle against a transaction-level timeline model.
module tb_jump_reg_ctrl;

  localparam int WIDTH = 32;
  localparam int FS    = 2;
`ifdef JUMP_REG_JALR_EN
  localparam bit JALR_EN = 1'b1;
`else
  localparam bit JALR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  jump_reg_ctrl_if #(.WIDTH(WIDTH)) bus ();

  jump_reg_ctrl #(.WIDTH(WIDTH), .FLUSH_STAGES(FS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_target = '0;
  logic [31:0] exp_link   = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input string ctx, input bit jr, input bit st, input bit rv,
                             input bit lv, input bit fl, input bit ae);
    chk({ctx, ".jr_control"},     32'(bus.jr_control),     32'(jr));
    chk({ctx, ".stall_out"},      32'(bus.stall_out),      32'(st));
    chk({ctx, ".redirect_valid"}, 32'(bus.redirect_valid), 32'(rv));
    chk({ctx, ".link_valid"},     32'(bus.link_valid),     32'(lv));
    chk({ctx, ".flush"},          32'(bus.flush),          32'(fl));
    chk({ctx, ".addr_err"},       32'(bus.addr_err),       32'(ae));
    chk({ctx, ".redirect_pc"},    bus.redirect_pc,         exp_target);
    chk({ctx, ".link_data"},      bus.link_data,           exp_link);
  endtask

  function automatic bit ref_hit(input logic [1:0] op, input logic [5:0] f);
    return (op == 2'b10) && ((f == 6'h08) || (JALR_EN && f == 6'h09));
  endfunction

  task automatic drive(input bit v, input logic [1:0] op, input logic [5:0] f,
                       input bit rdy, input logic [31:0] rs, input logic [31:0] pc4);
    @(posedge clk);
    #1;
    bus.valid_in = v;
    bus.alu_op   = op;
    bus.fn       = f;
    bus.rs_ready = rdy;
    bus.rs_data  = rs;
    bus.pc_plus4 = pc4;
    #1;
  endtask

  // One jump transaction: k stall cycles, accept, then redirect/flush or addr_err.
  // With junk set, a valid JR is presented throughout the redirect/flush window.
  task automatic jump(input string name, input logic [1:0] op, input logic [5:0] f,
                      input logic [31:0] tgt, input logic [31:0] pc4, input int k, input bit junk);
    bit h       = ref_hit(op, f);
    bit is_jalr = h && (f == 6'h09);
    bit bad     = (tgt[1:0] != 2'b00);
    $display("txn %s op=%0d fn=%h tgt=%h pc4=%h wait=%0d junk=%0d hit=%0d",
             name, op, f, tgt, pc4, k, junk, h);
    if (!h) begin
      drive(1'b1, op, f, 1'b1, tgt, pc4);
      check_cycle({name, ".nohit"}, 0, 0, 0, 0, 0, 0);
      drive(1'b0, 2'b00, 6'h00, 1'b0, 32'h0, 32'h0);
      check_cycle({name, ".nohit_after"}, 0, 0, 0, 0, 0, 0);
      return;
    end
    for (int i = 0; i < k; i++) begin
      drive(1'b1, op, f, 1'b0, $urandom, pc4);
      check_cycle({name, ".wait"}, 1, 1, 0, 0, 0, 0);
    end
    drive(1'b1, op, f, 1'b1, tgt, pc4);
    check_cycle({name, ".accept"}, 1, 0, 0, 0, 0, 0);
    exp_target = tgt;
    if (JALR_EN) exp_link = pc4;
    if (bad) begin
      drive(1'b0, 2'b00, 6'h00, 1'b0, 32'h0, 32'h0);
      check_cycle({name, ".addr_err"}, 0, 0, 0, 0, 0, 1);
      return;
    end
    for (int c = 0; c < FS; c++) begin
      if (junk) drive(1'b1, 2'b10, 6'h08, 1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom);
      else      drive(1'b0, 2'b00, 6'h00, 1'b0, 32'h0, 32'h0);
      check_cycle({name, (c == 0) ? ".redirect" : ".flush"}, junk, 0, c == 0,
                  (c == 0) && is_jalr, 1, 0);
    end
  endtask

  task automatic squash(input int k);
    $display("txn squash wait=%0d", k);
    for (int i = 0; i < k; i++) begin
      drive(1'b1, 2'b10, 6'h08, 1'b0, $urandom, 32'h600);
      check_cycle("squash.wait", 1, 1, 0, 0, 0, 0);
    end
    drive(1'b0, 2'b00, 6'h00, 1'b0, 32'h0, 32'h0);
    check_cycle("squash.drop", 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < FS + 1; i++) begin
      drive(1'b0, 2'b00, 6'h00, 1'b1, 32'h0, 32'h0);
      check_cycle("squash.idle", 0, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.valid_in = 1'b0;
    bus.alu_op   = 2'b00;
    bus.fn       = 6'h00;
    bus.rs_ready = 1'b0;
    bus.rs_data  = '0;
    bus.pc_plus4 = '0;
    @(posedge clk);
    #1;
    check_cycle("reset", 0, 0, 0, 0, 0, 0);
    drive(1'b0, 2'b00, 6'h00, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    drive(1'b0, 2'b00, 6'h00, 1'b0, 32'h0, 32'h0);
    check_cycle("post_reset", 0, 0, 0, 0, 0, 0);

    jump("jr_basic",   2'b10, 6'h08, 32'h0040_0100, 32'h0000_0104, 0, 1'b0);
    jump("jr_wait3",   2'b10, 6'h08, 32'h0000_1000, 32'h0000_0200, 3, 1'b0);
    jump("jalr",       2'b10, 6'h09, 32'h0000_0800, 32'h0000_0204, 0, 1'b0);
    jump("jr_misalgn", 2'b10, 6'h08, 32'h0000_0102, 32'h0000_0300, 0, 1'b0);
    jump("jr_junk",    2'b10, 6'h08, 32'h0000_2000, 32'h0000_0400, 0, 1'b1);
    jump("jr_b2b",     2'b10, 6'h08, 32'h0000_3000, 32'h0000_0500, 0, 1'b0);
    jump("other_op",   2'b00, 6'h08, 32'h0000_4000, 32'h0000_0600, 0, 1'b0);
    squash(2);

    for (int n = 0; n < 40; n++) begin
      int unsigned sel = $urandom_range(0, 4);
      logic [1:0]  op  = 2'b10;
      logic [5:0]  f   = 6'h08;
      logic [31:0] tgt = $urandom & 32'hFFFF_FFFC;
      if (sel == 2) f = 6'h09;
      if (sel == 3) f = 6'($urandom);
      if (sel == 4) op = 2'($urandom_range(0, 1)) | {1'b0, 1'($urandom)} ;
      if ($urandom_range(0, 4) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      jump("rand", op, f, tgt, $urandom & 32'hFFFF_FFFC,
           int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("txn reset_in_wait");
    drive(1'b1, 2'b10, 6'h08, 1'b0, 32'h0000_5000, 32'h700);
    check_cycle("rstwait.wait", 1, 1, 0, 0, 0, 0);
    drive(1'b1, 2'b10, 6'h08, 1'b0, 32'h0000_5000, 32'h700);
    check_cycle("rstwait.wait", 1, 1, 0, 0, 0, 0);
    #2;
    rst_n      = 1'b0;
    exp_target = '0;
    exp_link   = '0;
    #1;
    check_cycle("rstwait.async", 0, 0, 0, 0, 0, 0);
    drive(1'b0, 2'b00, 6'h00, 1'b1, 32'h0000_5000, 32'h700);
    rst_n = 1'b1;
    for (int i = 0; i < FS + 2; i++) begin
      drive(1'b0, 2'b00, 6'h00, 1'b1, 32'h0000_5000, 32'h700);
      check_cycle("rstwait.after", 0, 0, 0, 0, 0, 0);
    end
    jump("jr_final", 2'b10, 6'h08, 32'h0000_6000, 32'h0000_0800, 1, 1'b0);
    drive(1'b0, 2'b00, 6'h00, 1'b0, 32'h0, 32'h0);
    check_cycle("final_idle", 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
